// File: rtl/fsm_cmd_arbiter_if.sv
// Requester and datapath bus of the command arbiter.
// master = arbiter side, slave = requesters plus datapath.
interface fsm_cmd_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int CMD_W = 3
);
    logic [NREQ-1:0]       req;
    logic [NREQ*CMD_W-1:0] cmd;
    logic [NREQ-1:0]       gnt;
    logic                  dp_valid;
    logic [CMD_W-1:0]      dp_cmd;
    logic                  dp_ready;
    logic                  dp_done;
    logic [CMD_W-1:0]      dp_result;
    logic [NREQ-1:0]       rsp_valid;
    logic [CMD_W-1:0]      rsp_data;

    modport master (
        input  req, cmd, dp_ready, dp_done, dp_result,
        output gnt, dp_valid, dp_cmd, rsp_valid, rsp_data
    );

    modport slave (
        output req, cmd, dp_ready, dp_done, dp_result,
        input  gnt, dp_valid, dp_cmd, rsp_valid, rsp_data
    );
endinterface

// File: rtl/fsm_cmd_arbiter.sv
// Round-robin arbiter sequencing NREQ requesters onto one command datapath.
// Define FSM_ARB_TIMEOUT_EN to bound the WAIT state to TIMEOUT cycles.
module fsm_cmd_arbiter #(
    parameter int NREQ    = 4,
    parameter int CMD_W   = 3,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    fsm_cmd_arbiter_if.master  bus,
    output logic               fsm_err,
    output logic               tmo
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || CMD_W < 1 || TIMEOUT < 1) begin : g_param_chk
        $error("fsm_cmd_arbiter: parameter out of range");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        ISSUE = 3'b001,
        WAIT  = 3'b010,
        RESP  = 3'b011
    } state_e;

    // Kept as a raw vector so the illegal codes 100..111 remain representable.
    logic [2:0]       state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic [CMD_W-1:0] rsp_data_q, rsp_data_d;
    logic             dp_valid_q, dp_valid_d;
    logic             fsm_err_q, fsm_err_d;

`ifdef FSM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;
`endif

    // Round-robin search starts one past the last winner.
    logic          found;
    logic [PW-1:0] win_idx;
    logic [PW-1:0] idx;
    logic [CMD_W-1:0] cmd_sel;

    always_comb begin
        found   = 1'b0;
        win_idx = ptr_q;
        idx     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = PW'((int'(ptr_q) + k) % NREQ);
            if (!found && bus.req[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
    end

    always_comb begin
        cmd_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == PW'(i)) cmd_sel = bus.cmd[i*CMD_W +: CMD_W];
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        ptr_d       = ptr_q;
        cmd_d       = cmd_q;
        dp_valid_d  = dp_valid_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        fsm_err_d   = 1'b0;
`ifdef FSM_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        tmo_d       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (found) begin
                    state_d    = ISSUE;
                    gnt_d      = NREQ'(1) << win_idx;
                    cmd_d      = cmd_sel;
                    ptr_d      = win_idx;
                    dp_valid_d = 1'b1;
                end
            end
            ISSUE: begin
                // A handshake beats a simultaneous request drop.
                if (bus.dp_ready) begin
                    state_d    = WAIT;
                    dp_valid_d = 1'b0;
`ifdef FSM_ARB_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end else if (!bus.req[ptr_q]) begin
                    state_d    = IDLE;
                    gnt_d      = '0;
                    dp_valid_d = 1'b0;
                end
            end
            WAIT: begin
                if (bus.dp_done) begin
                    state_d     = RESP;
                    rsp_data_d  = bus.dp_result;
                    rsp_valid_d = gnt_q;
                end
`ifdef FSM_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d     = RESP;
                    rsp_data_d  = '1;
                    rsp_valid_d = gnt_q;
                    tmo_d       = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d    = IDLE;
                gnt_d      = '0;
                dp_valid_d = 1'b0;
                fsm_err_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            ptr_q       <= PW'(NREQ - 1);
            cmd_q       <= '0;
            dp_valid_q  <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            fsm_err_q   <= 1'b0;
`ifdef FSM_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            tmo_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            ptr_q       <= ptr_d;
            cmd_q       <= cmd_d;
            dp_valid_q  <= dp_valid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            fsm_err_q   <= fsm_err_d;
`ifdef FSM_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.dp_valid  = dp_valid_q;
    assign bus.dp_cmd    = cmd_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign fsm_err       = fsm_err_q;
`ifdef FSM_ARB_TIMEOUT_EN
    assign tmo = tmo_q;
`else
    assign tmo = 1'b0;
`endif
endmodule

// File: tb/tb_fsm_cmd_arbiter.sv
// Directed bench for fsm_cmd_arbiter: inputs change and outputs are sampled on negedge.
module tb_fsm_cmd_arbiter;
    logic clk;
    logic rst_n;
    logic fsm_err;
    logic tmo;
    int   n_cmp;
    int   n_err;
    int   w;
    logic [3:0] e;

    fsm_cmd_arbiter_if #(.NREQ(4), .CMD_W(3)) bus ();

    fsm_cmd_arbiter #(.NREQ(4), .CMD_W(3), .TIMEOUT(15)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.master),
        .fsm_err (fsm_err),
        .tmo     (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.req = '0;
        bus.cmd = '0;
        bus.dp_ready = 1'b0;
        bus.dp_done = 1'b0;
        bus.dp_result = '0;
        #1;
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_dp_valid", bus.dp_valid, 0);
        chk("rst_dp_cmd", bus.dp_cmd, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_fsm_err", fsm_err, 0);
        chk("rst_tmo", tmo, 0);
        tick(2);
        rst_n = 1'b1;

        // Single requester, cmd0=5, done two cycles after the handshake.
        bus.req = 4'b0001; bus.cmd = 12'h005; bus.dp_ready = 1'b1;
        tick(1);
        chk("t2_gnt", bus.gnt, 4'b0001);
        chk("t2_dp_valid", bus.dp_valid, 1);
        chk("t2_dp_cmd", bus.dp_cmd, 5);
        tick(1);
        chk("t2_wait_dp_valid", bus.dp_valid, 0);
        chk("t2_wait_gnt", bus.gnt, 4'b0001);
        tick(1);
        chk("t2_no_rsp_yet", bus.rsp_valid, 0);
        bus.dp_done = 1'b1; bus.dp_result = 3'd3;
        tick(1);
        chk("t2_rsp_valid", bus.rsp_valid, 4'b0001);
        chk("t2_rsp_data", bus.rsp_data, 3);
        bus.dp_done = 1'b0; bus.req = 4'b0000;
        tick(1);
        chk("t2_rsp_off", bus.rsp_valid, 0);
        chk("t2_gnt_off", bus.gnt, 0);
        chk("t2_rsp_hold", bus.rsp_data, 3);

        // Asynchronous reset while in WAIT.
        bus.req = 4'b0010; bus.cmd = 12'h030;
        tick(1);
        chk("t1_gnt", bus.gnt, 4'b0010);
        chk("t1_dp_cmd", bus.dp_cmd, 6);
        tick(1);
        chk("t1_in_wait", dut.state_q, 3'b010);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_async_gnt", bus.gnt, 0);
        chk("t1_async_dp_cmd", bus.dp_cmd, 0);
        chk("t1_async_rsp_data", bus.rsp_data, 0);
        chk("t1_async_state", dut.state_q, 0);
        tick(3);
        rst_n = 1'b1;

        // All four requesting: grants rotate 0,1,2,3,0 starting from reset.
        bus.req = 4'b1111; bus.cmd = 12'h8D1;
        bus.dp_ready = 1'b1; bus.dp_done = 1'b1; bus.dp_result = 3'd6;
        for (int t = 0; t < 5; t++) begin
            w = t % 4;
            e = 4'b0001 << w;
            tick(1);
            chk("rr_gnt", bus.gnt, e);
            chk("rr_dp_valid", bus.dp_valid, 1);
            chk("rr_dp_cmd", bus.dp_cmd, w + 1);
            tick(2);
            chk("rr_rsp_valid", bus.rsp_valid, e);
            chk("rr_rsp_data", bus.rsp_data, 6);
            tick(1);
            chk("rr_idle_gnt", bus.gnt, 0);
        end
        bus.req = 4'b0000;

        // Abort in ISSUE, then ptr=1 makes requester 0 win over 1.
        bus.dp_ready = 1'b0; bus.dp_done = 1'b0; bus.req = 4'b0010;
        tick(1);
        chk("t4_gnt", bus.gnt, 4'b0010);
        chk("t4_dp_valid", bus.dp_valid, 1);
        bus.req = 4'b0000;
        tick(1);
        chk("t4_abort_gnt", bus.gnt, 0);
        chk("t4_abort_dp_valid", bus.dp_valid, 0);
        chk("t4_abort_rsp", bus.rsp_valid, 0);
        chk("t4_abort_state", dut.state_q, 0);
        bus.req = 4'b0011;
        tick(1);
        chk("t4_regrant", bus.gnt, 4'b0001);
        chk("t4_regrant_cmd", bus.dp_cmd, 1);
        bus.dp_ready = 1'b1; bus.dp_done = 1'b1;
        tick(2);
        chk("t4_rsp", bus.rsp_valid, 4'b0001);
        bus.req = 4'b0000;
        tick(1);

        // Handshake in the same cycle req drops: transaction still completes.
        bus.dp_ready = 1'b0; bus.dp_done = 1'b0; bus.req = 4'b0100;
        tick(1);
        chk("hs_gnt", bus.gnt, 4'b0100);
        bus.dp_ready = 1'b1; bus.req = 4'b0000;
        tick(1);
        chk("hs_state_wait", dut.state_q, 3'b010);
        chk("hs_gnt_held", bus.gnt, 4'b0100);
        bus.dp_done = 1'b1; bus.dp_result = 3'd5;
        tick(1);
        chk("hs_rsp_valid", bus.rsp_valid, 4'b0100);
        chk("hs_rsp_data", bus.rsp_data, 5);
        bus.dp_done = 1'b0; bus.dp_ready = 1'b0;
        tick(1);

        // Illegal state recovery from ISSUE; ptr must stay at the winner (0).
        bus.req = 4'b0001;
        tick(1);
        chk("t5_pre_gnt", bus.gnt, 4'b0001);
        force dut.state_q = 3'b110;
        bus.req = 4'b0000;
        #1 release dut.state_q;
        tick(1);
        chk("t5_state", dut.state_q, 0);
        chk("t5_fsm_err", fsm_err, 1);
        chk("t5_gnt", bus.gnt, 0);
        chk("t5_dp_valid", bus.dp_valid, 0);
        chk("t5_rsp_valid", bus.rsp_valid, 0);
        tick(1);
        chk("t5_fsm_err_pulse", fsm_err, 0);
        bus.req = 4'b1111;
        tick(1);
        chk("t5_ptr_kept", bus.gnt, 4'b0010);
        bus.dp_ready = 1'b1; bus.dp_done = 1'b1; bus.dp_result = 3'd2;
        tick(2);
        chk("t5_rsp", bus.rsp_valid, 4'b0010);
        chk("t5_rsp_data", bus.rsp_data, 2);
        bus.req = 4'b0000;
        tick(1);

        // WAIT with dp_done never arriving.
        bus.dp_done = 1'b0; bus.req = 4'b0001;
        tick(1);
        chk("t6_gnt", bus.gnt, 4'b0001);
        tick(1);
        chk("t6_in_wait", dut.state_q, 3'b010);
`ifdef FSM_ARB_TIMEOUT_EN
        tick(14);
        chk("t6_still_wait", dut.state_q, 3'b010);
        chk("t6_tmo_early", tmo, 0);
        chk("t6_rsp_early", bus.rsp_valid, 0);
        tick(1);
        chk("t6_tmo", tmo, 1);
        chk("t6_rsp_valid", bus.rsp_valid, 4'b0001);
        chk("t6_rsp_data", bus.rsp_data, 7);
        bus.req = 4'b0000;
        tick(1);
        chk("t6_tmo_pulse", tmo, 0);
`else
        tick(100);
        chk("t6_stuck_wait", dut.state_q, 3'b010);
        chk("t6_tmo_zero", tmo, 0);
        chk("t6_no_rsp", bus.rsp_valid, 0);
        chk("t6_gnt_held", bus.gnt, 4'b0001);
        bus.req = 4'b0000;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fsm_cmd_arbiter.md
Name: fsm_cmd_arbiter

Overview:
Round-robin arbiter and sequencer that shares one mode-FSM datapath among NREQ requesters. Each requester submits a 3-bit command. The arbiter grants one requester and issues its command to the datapath with a valid/ready handshake. It then waits for completion and returns the result to the granted requester. The controller FSM has fully specified encodings and recovers from illegal states.

Parameters:
NREQ, 4, number of requesters (2..8)
CMD_W, 3, command/result width
TIMEOUT, 15, WAIT-state timeout in cycles (used only with FSM_ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active-low
req  in  NREQ  request per requester; level, held until rsp_valid or abort
cmd  in  NREQ*CMD_W  command per requester; requester i uses bits [i*CMD_W +: CMD_W]
gnt  out  NREQ  one-hot grant, registered
dp_valid  out  1  command valid to datapath
dp_cmd  out  CMD_W  command to datapath
dp_ready  in  1  datapath accepts command
dp_done  in  1  datapath completion pulse
dp_result  in  CMD_W  datapath result, valid with dp_done
rsp_valid  out  NREQ  one-cycle response strobe to granted requester
rsp_data  out  CMD_W  response data, valid with rsp_valid
fsm_err  out  1  one-cycle pulse on illegal-state recovery
tmo  out  1  one-cycle pulse on WAIT timeout

Behaviour:
- Reset (async, rst_n=0):
  - All outputs are 0 and state=IDLE.
  - Round-robin pointer ptr=NREQ-1, so the first search starts at requester 0.
  - Internal cmd_q=0.
- States, 3-bit encoding: IDLE=000, ISSUE=001, WAIT=010, RESP=011. Encodings 100..111 are illegal.
- IDLE:
  - If any req bit is set, select the first set bit searching ptr+1, ptr+2, ... modulo NREQ.
  - Register gnt one-hot, latch that requester's cmd into cmd_q, set ptr to the winner, go to ISSUE.
  - gnt rises the cycle after req is sampled.
  - If no req is set, stay in IDLE with gnt=0.
- ISSUE:
  - dp_valid=1, dp_cmd=cmd_q, both stable until the handshake.
  - On dp_valid & dp_ready, go to WAIT.
  - If req[winner]=0 and dp_ready=0 in the same cycle, abort: go to IDLE, clear gnt, dp_valid=0 next cycle, no rsp. ptr keeps the winner.
  - If the handshake occurs in the same cycle as req drops, the handshake wins and the transaction completes.
- WAIT:
  - dp_valid=0, gnt held.
  - On dp_done, capture dp_result into rsp_data and go to RESP.
  - A req drop in WAIT is ignored; the transaction completes.
- RESP:
  - rsp_valid[winner]=1 for exactly one cycle; rsp_data is held until the next RESP.
  - gnt clears on the transition to IDLE.
- dp_done outside WAIT is ignored.
- dp_cmd=cmd_q in all states; it is only meaningful while dp_valid=1.
- Minimum transaction with dp_ready and dp_done both asserted early: IDLE→ISSUE→WAIT→RESP→IDLE, 4 cycles. Back-to-back requests re-arbitrate in the IDLE cycle after RESP.
- Illegal state: next state is IDLE; gnt, dp_valid and rsp_valid go to 0; fsm_err pulses for one cycle; ptr is unchanged.
- All CMD_W command values are legal and passed through unmodified.
- Outputs are registered or decoded from state only, never directly from req.

Optional Feature:
FSM_ARB_TIMEOUT_EN
- Defined:
  - A counter runs in WAIT, cleared on WAIT entry.
  - After TIMEOUT cycles in WAIT with no dp_done, go to RESP with rsp_data all ones (3'b111) and pulse tmo for one cycle.
  - If dp_done arrives on the timeout cycle, dp_done wins and tmo stays 0.
- Undefined: WAIT has no time limit, no counter is built, and tmo is tied to 0.

Test Plan:
1. rst_n low for 3 cycles mid-transaction (state WAIT) → all outputs 0 immediately (asynchronous); after release, the first grant goes to req0 when req=1111.
2. req=0001, cmd0=5, dp_ready=1, dp_done=1 two cycles after the handshake with dp_result=3 → gnt=0001, dp_valid for one cycle with dp_cmd=5, rsp_valid=0001 with rsp_data=3.
3. req=1111 held, immediate ready/done → grant sequence 0,1,2,3,0, with each rsp_valid one-hot and matching its grant.
4. req=0010 granted, dp_ready=0, drop req1 in ISSUE → IDLE next cycle, gnt=0, no rsp_valid; then req=0011 → grant goes to requester 0 (ptr=1).
5. Bench forces state to 3'b110 → next cycle state=IDLE, fsm_err=1 for exactly one cycle, gnt=0.
6. With FSM_ARB_TIMEOUT_EN and TIMEOUT=15, dp_done never asserted → after 15 WAIT cycles, tmo pulse plus rsp_valid with rsp_data=7. Without the macro → still in WAIT after 100 cycles and tmo=0.
